pipeline_perf_counter: RTL and testbench

- Synthesizable, multi-channel event and cycle counter for the pipelined CPU.
- Counts run cycles and per-channel pipeline events (stall, flush, branch-taken, load-use, etc.), stops automatically after a programmable cycle budget, and exposes a coherent snapshot through a read port.
- Sits beside CPU, fed by hazard-detection and control signals. It replaces ad-hoc stall/flush counting in benches and can also be observed in hardware.

---
 rtl/pipeline_perf_counter_if.sv | 30 +++
 rtl/pipeline_perf_counter.sv | 108 ++++++++++
 tb/tb_pipeline_perf_counter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_perf_counter_if.sv
// Control, event and snapshot-read signals of the pipeline performance counter.
// The master side drives the inputs, the slave side is the counter block.
interface pipeline_perf_counter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic              start_i;
  logic              clear_i;
  logic [NUM_CH-1:0] event_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic              snap_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic [CNT_W-1:0]  rd_data_o;
  logic              snap_valid_o;
  logic [NUM_CH:0]   overflow_o;
  logic              running_o;
  logic              done_o;

  modport master (
    output start_i, clear_i, event_i, ch_en_i, snap_i, rd_sel_i,
    input  rd_data_o, snap_valid_o, overflow_o, running_o, done_o
  );

  modport slave (
    input  start_i, clear_i, event_i, ch_en_i, snap_i, rd_sel_i,
    output rd_data_o, snap_valid_o, overflow_o, running_o, done_o
  );
endinterface

// File: rtl/pipeline_perf_counter.sv
// Multi-channel cycle/event performance counter with a cycle-budget auto-stop
// and a coherent shadow snapshot behind a combinational read port.
module pipeline_perf_counter #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter int SAT_MODE   = 0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  pipeline_perf_counter_if.slave bus
);
  // Counter 0 is the cycle counter, counter k is event channel k-1.
  localparam int          NCNT   = NUM_CH + 1;
  localparam logic [63:0] BUDGET = 64'(MAX_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic             running;
  logic             done;
  logic             snap_valid;
  logic [NUM_CH:0]  overflow;
  logic [CNT_W-1:0] live   [NCNT];
  logic [CNT_W-1:0] shadow [NCNT];
  logic             counting;
  logic             budget_hit;
  logic [NUM_CH:0]  inc;
  logic [CNT_W-1:0] rd_data;

  assign counting   = (state == RUN) && bus.start_i;
  assign inc        = {bus.event_i & bus.ch_en_i, 1'b1} & {NCNT{counting}};
  assign budget_hit = (MAX_CYCLES != 0) && (64'(live[0]) + 64'd1 == BUDGET);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (int'(bus.rd_sel_i) == k) rd_data = shadow[k];
    end
  end

  // NOTE: the counter arrays are plain flops, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      snap_valid <= 1'b0;
      overflow   <= '0;
      for (int k = 0; k < NCNT; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
    end else if (bus.clear_i) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      snap_valid <= 1'b0;
      overflow   <= '0;
      for (int k = 0; k < NCNT; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make the shadow copy see live values from before this edge's increments.
      snap_valid <= bus.snap_i;
      for (int k = 0; k < NCNT; k++) begin
        if (bus.snap_i) shadow[k] <= live[k];
        if (inc[k]) begin
          if (&live[k]) begin
            overflow[k] <= 1'b1;
            if (SAT_MODE == 0) live[k] <= '0;
          end else begin
            live[k] <= live[k] + CNT_W'(1);
          end
        end
      end

      unique case (state)
        IDLE, PAUSE: begin
          if (bus.start_i) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.start_i) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (budget_hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.rd_data_o    = rd_data;
  assign bus.snap_valid_o = snap_valid;
  assign bus.overflow_o   = overflow;
  assign bus.running_o    = running;
  assign bus.done_o       = done;
endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Bench for pipeline_perf_counter: three configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_pipeline_perf_counter;
  localparam int NCH = 4;
  localparam int NI  = 3;
  localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, clr = 1'b0, snp = 1'b0;
  logic [NCH-1:0] ev = '0, en = '0;
  logic [2:0]     sel = '0;

  int tests = 0;
  int fails = 0;

  // Instance 0: 32-bit, budget 30, wrap. 1: 4-bit, unlimited, wrap. 2: 4-bit, unlimited, saturate.
  int cw   [NI] = '{32, 4, 4};
  int maxc [NI] = '{30, 0, 0};
  bit satm [NI] = '{1'b0, 1'b0, 1'b1};

  pipeline_perf_counter_if #(.NUM_CH(NCH), .CNT_W(32)) if_a ();
  pipeline_perf_counter_if #(.NUM_CH(NCH), .CNT_W(4))  if_b ();
  pipeline_perf_counter_if #(.NUM_CH(NCH), .CNT_W(4))  if_c ();

  assign {if_a.start_i, if_a.clear_i, if_a.snap_i, if_a.event_i, if_a.ch_en_i, if_a.rd_sel_i} = {start, clr, snp, ev, en, sel};
  assign {if_b.start_i, if_b.clear_i, if_b.snap_i, if_b.event_i, if_b.ch_en_i, if_b.rd_sel_i} = {start, clr, snp, ev, en, sel};
  assign {if_c.start_i, if_c.clear_i, if_c.snap_i, if_c.event_i, if_c.ch_en_i, if_c.rd_sel_i} = {start, clr, snp, ev, en, sel};

  pipeline_perf_counter #(.NUM_CH(NCH), .CNT_W(32), .MAX_CYCLES(30), .SAT_MODE(0))
    dut_a (.clk_i(clk), .rst_i(rst_n), .bus(if_a));
  pipeline_perf_counter #(.NUM_CH(NCH), .CNT_W(4), .MAX_CYCLES(0), .SAT_MODE(0))
    dut_b (.clk_i(clk), .rst_i(rst_n), .bus(if_b));
  pipeline_perf_counter #(.NUM_CH(NCH), .CNT_W(4), .MAX_CYCLES(0), .SAT_MODE(1))
    dut_c (.clk_i(clk), .rst_i(rst_n), .bus(if_c));

  always #5 clk = ~clk;

  // Behavioural model: counts as unbounded integers folded into the counter range.
  int           m_phase [NI];
  longint       m_live  [NI][NCH+1];
  longint       m_shad  [NI][NCH+1];
  bit [NCH:0]   m_ovf   [NI];
  bit           m_snapv [NI];

  function automatic void model_reset(int i);
    m_phase[i] = P_IDLE;
    m_ovf[i]   = '0;
    m_snapv[i] = 1'b0;
    for (int k = 0; k <= NCH; k++) begin
      m_live[i][k] = 0;
      m_shad[i][k] = 0;
    end
  endfunction

  function automatic void model_step(int i);
    longint top = (longint'(1) << cw[i]) - 1;
    longint nv;
    bit     counting;
    if (clr) begin
      model_reset(i);
      return;
    end
    m_snapv[i] = snp;
    if (snp) for (int k = 0; k <= NCH; k++) m_shad[i][k] = m_live[i][k];
    counting = (m_phase[i] == P_RUN) && start;
    if (counting) begin
      for (int k = 0; k <= NCH; k++) begin
        if (k == 0 || (ev[k-1] && en[k-1])) begin
          nv = m_live[i][k] + 1;
          if (nv > top) begin
            m_ovf[i][k] = 1'b1;
            nv = satm[i] ? top : nv % (top + 1);
          end
          m_live[i][k] = nv;
        end
      end
    end
    case (m_phase[i])
      P_IDLE, P_PAUSE: if (start) m_phase[i] = P_RUN;
      P_RUN: begin
        if (!start) m_phase[i] = P_PAUSE;
        else if (maxc[i] != 0 && m_live[i][0] == longint'(maxc[i])) m_phase[i] = P_DONE;
      end
      default: ;
    endcase
  endfunction

  logic [63:0]  p_rd;
  logic [NCH:0] p_ov;
  logic         p_run, p_dn, p_sv;

  task automatic probe(input int i);
    case (i)
      0: begin p_rd = 64'(if_a.rd_data_o); p_ov = if_a.overflow_o; p_run = if_a.running_o; p_dn = if_a.done_o; p_sv = if_a.snap_valid_o; end
      1: begin p_rd = 64'(if_b.rd_data_o); p_ov = if_b.overflow_o; p_run = if_b.running_o; p_dn = if_b.done_o; p_sv = if_b.snap_valid_o; end
      default: begin p_rd = 64'(if_c.rd_data_o); p_ov = if_c.overflow_o; p_run = if_c.running_o; p_dn = if_c.done_o; p_sv = if_c.snap_valid_o; end
    endcase
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare();
    logic [63:0] exp_rd;
    for (int i = 0; i < NI; i++) begin
      probe(i);
      exp_rd = 0;
      if (sel <= 3'(NCH)) exp_rd = 64'(m_shad[i][sel]);
      check($sformatf("inst%0d rd_data sel%0d", i, sel), p_rd, exp_rd);
      check($sformatf("inst%0d overflow", i), 64'(p_ov), 64'(m_ovf[i]));
      check($sformatf("inst%0d running", i), 64'(p_run), 64'(m_phase[i] == P_RUN));
      check($sformatf("inst%0d done", i), 64'(p_dn), 64'(m_phase[i] == P_DONE));
      check($sformatf("inst%0d snap_valid", i), 64'(p_sv), 64'(m_snapv[i]));
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic peek(input string nm, input int i, input int k, input logic [63:0] exp);
    sel = 3'(k);
    #1;
    probe(i);
    check(nm, p_rd, exp);
  endtask

  task automatic clear_all();
    clr = 1'b1; start = 1'b0; snp = 1'b0; ev = '0; en = '0;
    tick();
    clr = 1'b0;
  endtask

  task automatic stop_and_snap();
    start = 1'b0; ev = '0; en = '0; snp = 1'b1;
    tick();
    snp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) model_reset(i);
    #12;
    compare();
    for (int k = 0; k < 8; k++) peek($sformatf("reset rd sel%0d", k), 0, k, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Budget run: 1 entry edge + 30 counted edges.
    clear_all();
    start = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      tick();
      probe(0);
      if (n == 30) check("budget done before last edge", 64'(p_dn), 0);
      if (n == 31) begin
        check("budget done after 30 counts", 64'(p_dn), 1);
        check("budget running cleared", 64'(p_run), 0);
      end
    end
    stop_and_snap();
    probe(0);
    check("budget snap_valid", 64'(p_sv), 1);
    peek("budget cycles", 0, 0, 30);
    for (int k = 1; k <= NCH; k++) peek($sformatf("budget ch%0d", k - 1), 0, k, 0);

    // Channel qualifier: event every edge, enabled on 5 of 10.
    clear_all();
    start = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin
      ev = 4'b0001;
      en = {3'b000, n[0] == 1'b0};
      tick();
    end
    stop_and_snap();
    peek("qualifier cycles", 1, 0, 10);
    peek("qualifier ch0", 1, 1, 5);

    // Pause for 4 cycles mid-run: 5 + 3 counted edges.
    clear_all();
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    repeat (4) tick();
    stop_and_snap();
    peek("pause cycles", 0, 0, 8);

    // 17 events on channel 1 into 4-bit counters.
    clear_all();
    start = 1'b1;
    tick();
    start = 1'b1; ev = 4'b0010; en = 4'b0010;
    repeat (17) tick();
    stop_and_snap();
    peek("wrap ch1", 1, 2, 1);
    check("wrap overflow bit2", 64'(p_ov[2]), 1);
    peek("sat ch1", 2, 2, 15);
    check("sat overflow bit2", 64'(p_ov[2]), 1);

    // Snapshot on the same edge as an event, then back-to-back snapshots.
    clear_all();
    start = 1'b1;
    tick();
    ev = 4'b0100; en = 4'b0100;
    repeat (7) tick();
    snp = 1'b1;
    tick();
    snp = 1'b0; ev = '0;
    probe(0);
    check("same-edge snap_valid", 64'(p_sv), 1);
    peek("same-edge snap ch2", 0, 3, 7);
    tick();
    probe(0);
    check("snap_valid one cycle", 64'(p_sv), 0);
    snp = 1'b1;
    tick();
    probe(0);
    check("back-to-back snap 1", 64'(p_sv), 1);
    tick();
    probe(0);
    check("back-to-back snap 2", 64'(p_sv), 1);
    snp = 1'b0;
    peek("later snap ch2", 0, 3, 8);
    tick();

    // Clear and snapshot together while DONE.
    clear_all();
    start = 1'b1;
    repeat (34) tick();
    clr = 1'b1; snp = 1'b1;
    tick();
    clr = 1'b0; snp = 1'b0; start = 1'b0;
    probe(0);
    check("clear in done: done", 64'(p_dn), 0);
    check("clear in done: snap_valid", 64'(p_sv), 0);
    check("clear in done: overflow", 64'(p_ov), 0);
    peek("clear in done: rd", 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      clr   = ($urandom_range(99, 0) < 3);
      snp   = ($urandom_range(9, 0) == 0);
      start = ($urandom_range(9, 0) < 8);
      ev    = 4'($urandom);
      en    = 4'($urandom);
      sel   = 3'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of a run.
    clear_all();
    start = 1'b1; ev = 4'b1111; en = 4'b1111;
    repeat (5) tick();
    snp = 1'b1;
    tick();
    snp = 1'b0;
    repeat (2) tick();
    sel = 3'd0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      model_reset(i);
      probe(i);
      check($sformatf("async reset inst%0d rd", i), p_rd, 0);
      check($sformatf("async reset inst%0d running", i), 64'(p_run), 0);
      check($sformatf("async reset inst%0d overflow", i), 64'(p_ov), 0);
    end
    #2;
    rst_n = 1'b1;
    start = 1'b0; ev = '0; en = '0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
